// File: rtl/reg_write_decoder_if.sv
// rtl/reg_write_decoder_if.sv - write request, forward compare and register-enable bundle
// Groups the write request, read-port compare addresses and the decoded
// register-file drive signals between the decoder and its neighbours.
interface reg_write_decoder_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
);
  localparam int NREGS = 1 << ADDR_W;

  // Write request side
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  // Read-port addresses used only for the forward compare
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;

  // Register-file drive and pending-stage visibility
  logic [NREGS-1:0]  reg_en;
  logic [WIDTH-1:0]  reg_data;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              fwd_a;
  logic              fwd_b;

  // Requester / observer side
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  reg_en, reg_data, pend_valid, pend_addr, fwd_a, fwd_b
  );

  // Decoder side
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output reg_en, reg_data, pend_valid, pend_addr, fwd_a, fwd_b
  );
endinterface

// File: rtl/reg_write_decoder.sv
// rtl/reg_write_decoder.sv - register file write-port decoder with one-cycle pending stage
// Captures one write request per cycle into a single-entry pending stage,
// decodes it into one-hot register load enables and flags read ports whose
// address matches the in-flight write. Writes to the zero register are
// consumed but never committed. All outputs come from registered state plus
// the read addresses; the write inputs never reach an output combinationally.
module reg_write_decoder #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input logic              clk,
  input logic              reset,
  reg_write_decoder_if.slave bus
);
  localparam int NREGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  // Belt-and-braces mask: the zero register's enable is cut at the decoder
  // output as well, not only through pend_valid.
  localparam logic [NREGS-1:0]  ZERO_MASK = NREGS'(1) << ZERO_REG;

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [WIDTH-1:0]  pend_data;
  logic [NREGS-1:0]  decoded;

  // Pending stage: every request overwrites it; address/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= bus.wr_en && (bus.wr_addr != ZERO_ADDR);
      if (bus.wr_en) begin
        pend_addr <= bus.wr_addr;
        pend_data <= bus.wr_data;
      end
    end
  end

  // Plain ADDR_W-to-NREGS decode of the pending address, ungated.
  always_comb begin
    decoded            = '0;
    decoded[pend_addr] = 1'b1;
  end

  assign bus.reg_en     = pend_valid ? (decoded & ~ZERO_MASK) : '0;
  assign bus.reg_data   = pend_data;
  assign bus.pend_valid = pend_valid;
  assign bus.pend_addr  = pend_addr;

  // Forward flags are combinational on the read addresses so the read mux
  // can pick the in-flight value in the same cycle the address arrives.
  assign bus.fwd_a = pend_valid && (bus.rd_addr_a == pend_addr);
  assign bus.fwd_b = pend_valid && (bus.rd_addr_b == pend_addr);
endmodule

// File: tb/tb_reg_write_decoder.sv
// tb/tb_reg_write_decoder.sv - self-checking bench for reg_write_decoder
module tb_reg_write_decoder;
  logic clk;
  logic reset;

  reg_write_decoder_if #(.WIDTH(64), .ADDR_W(5)) bus ();

  reg_write_decoder #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the last accepted request and its committed effect.
  bit          m_valid;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  logic [63:0] model_rf [32];
  int          model_cnt [32];

  // Register file rebuilt from what the DUT actually drove.
  logic [63:0] dut_rf [32];
  int          dut_cnt [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 32; i++) begin
      model_cnt[i] = 0;
      dut_cnt[i]   = 0;
    end
  endtask

  task automatic drive(input logic en, input logic [4:0] a, input logic [63:0] d);
    bus.wr_en   = en;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  // One clock edge: record what the DUT commits, advance the model, settle.
  task automatic tick();
    logic [31:0] cap_en;
    logic [63:0] cap_data;
    cap_en   = bus.reg_en;
    cap_data = bus.reg_data;
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      if (cap_en[i] === 1'b1) begin
        dut_rf[i] = cap_data;
        dut_cnt[i]++;
      end
    end
    if (m_valid) begin
      model_rf[m_addr] = m_data;
      model_cnt[m_addr]++;
    end
    if (reset) begin
      model_reset();
    end else begin
      m_valid = bus.wr_en && (bus.wr_addr != 5'd31);
      if (bus.wr_en) begin
        m_addr = bus.wr_addr;
        m_data = bus.wr_data;
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_en;
    exp_en = m_valid ? (32'd1 << m_addr) : 32'd0;
    chk({tag, ".reg_en"},     64'(bus.reg_en),     64'(exp_en));
    chk({tag, ".reg_data"},   bus.reg_data,        m_data);
    chk({tag, ".pend_valid"}, 64'(bus.pend_valid), 64'(m_valid));
    chk({tag, ".pend_addr"},  64'(bus.pend_addr),  64'(m_addr));
    chk({tag, ".fwd_a"},      64'(bus.fwd_a),      64'(m_valid && bus.rd_addr_a == m_addr));
    chk({tag, ".fwd_b"},      64'(bus.fwd_b),      64'(m_valid && bus.rd_addr_b == m_addr));
  endtask

  initial begin
    logic [63:0] d;
    logic [4:0]  a;

    model_reset();
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
    clear_counts();

    // Reset held with garbage on every input
    reset = 1'b1;
    drive(1'b1, 5'd6, 64'hA5A5_5A5A_FFFF_0000);
    bus.rd_addr_a = 5'd6;
    bus.rd_addr_b = 5'd6;
    tick();
    tick();
    check_all("reset");
    chk("reset.reg_en_zero", 64'(bus.reg_en), 64'h0);
    #2;
    reset = 1'b0;
    drive(1'b0, 5'd0, 64'h0);
    bus.rd_addr_a = 5'd0;
    bus.rd_addr_b = 5'd1;

    // Single write to X5, then idle
    drive(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0005);
    tick();
    check_all("single");
    chk("single.reg_en_const", 64'(bus.reg_en), 64'h20);
    chk("single.data_const", bus.reg_data, 64'hDEAD_BEEF_0000_0005);
    drive(1'b0, 5'd0, 64'h0);
    tick();
    check_all("single_idle");
    chk("single_idle.reg_en_const", 64'(bus.reg_en), 64'h0);

    // Back-to-back 3, 3, 7 then idle
    drive(1'b1, 5'd3, 64'h1111);
    tick();
    chk("b2b0.reg_en", 64'(bus.reg_en), 64'h8);
    chk("b2b0.data", bus.reg_data, 64'h1111);
    drive(1'b1, 5'd3, 64'h2222);
    tick();
    chk("b2b1.reg_en", 64'(bus.reg_en), 64'h8);
    chk("b2b1.data", bus.reg_data, 64'h2222);
    drive(1'b1, 5'd7, 64'h3333);
    tick();
    chk("b2b2.reg_en", 64'(bus.reg_en), 64'h80);
    chk("b2b2.data", bus.reg_data, 64'h3333);
    drive(1'b0, 5'd0, 64'h0);
    tick();
    chk("b2b3.reg_en", 64'(bus.reg_en), 64'h0);
    chk("b2b.x3_final", dut_rf[3], 64'h2222);

    // Zero register write is consumed and dropped
    drive(1'b1, 5'd31, 64'h1);
    tick();
    bus.rd_addr_a = 5'd31;
    #1;
    check_all("zero");
    chk("zero.pend_valid_const", 64'(bus.pend_valid), 64'h0);
    chk("zero.pend_addr_const", 64'(bus.pend_addr), 64'd31);
    chk("zero.fwd_a_const", 64'(bus.fwd_a), 64'h0);

    // Forwarding: compare follows rd_addr without a clock edge
    drive(1'b1, 5'd12, 64'hC0C0_0000_0000_000C);
    tick();
    drive(1'b0, 5'd0, 64'h0);
    bus.rd_addr_a = 5'd12;
    bus.rd_addr_b = 5'd13;
    #1;
    chk("fwd.a_hit", 64'(bus.fwd_a), 64'h1);
    chk("fwd.b_miss", 64'(bus.fwd_b), 64'h0);
    bus.rd_addr_b = 5'd12;
    #1;
    chk("fwd.b_hit", 64'(bus.fwd_b), 64'h1);
    check_all("fwd");
    tick();

    // Reset pulsed mid-cycle discards a pending write to X9
    clear_counts();
    drive(1'b1, 5'd9, 64'h9999_0000_0000_0009);
    tick();
    chk("rst_mid.before", 64'(bus.reg_en), 64'h200);
    drive(1'b0, 5'd0, 64'h0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid.async");
    chk("rst_mid.reg_en_zero", 64'(bus.reg_en), 64'h0);
    #1;
    reset = 1'b0;
    tick();
    chk("rst_mid.no_load", 64'(dut_cnt[9]), 64'h0);
    chk("rst_mid.model_no_load", 64'(model_cnt[9]), 64'h0);

    // Sweep every address once, including the zero register
    clear_counts();
    for (int i = 0; i < 32; i++) begin
      d = {$urandom, $urandom};
      drive(1'b1, 5'(i), d);
      tick();
      check_all("sweep");
    end
    drive(1'b0, 5'd0, 64'h0);
    tick();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("sweep.cnt%0d", i), 64'(dut_cnt[i]), (i == 31) ? 64'd0 : 64'd1);
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = 5'd31;
      drive(1'($urandom_range(0, 3) != 0), a, {$urandom, $urandom});
      bus.rd_addr_a = 5'($urandom_range(0, 31));
      bus.rd_addr_b = 5'($urandom_range(0, 31));
      tick();
      check_all("rand");
      if ($urandom_range(0, 2) == 0) bus.rd_addr_a = m_addr;
      if ($urandom_range(0, 2) == 0) bus.rd_addr_b = m_addr;
      #1;
      chk("rand.fwd_a_mid", 64'(bus.fwd_a), 64'(m_valid && bus.rd_addr_a == m_addr));
      chk("rand.fwd_b_mid", 64'(bus.fwd_b), 64'(m_valid && bus.rd_addr_b == m_addr));
    end
    drive(1'b0, 5'd0, 64'h0);
    tick();
    tick();

    // Register file contents built from DUT enables must match the model
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("final.rf%0d", i), dut_rf[i], model_rf[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reg_write_decoder.md
# reg_write_decoder

Write-port front end for the 32 x 64-bit register file: the decode side that pairs with the read-port multiplexer tree. It accepts one write request per cycle and holds it for exactly one cycle in a single-entry pending stage. From that stage it drives a one-hot enable for each of the 32 register DFF banks, plus the write data. It also flags read ports whose address matches the pending write, so the read mux tree can forward the in-flight value. X31 (XZR) is never written.

## Interface

Parameters:
- WIDTH, 64, data width of one register
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W = 32
- ZERO_REG, 31, hardwired-zero register index; writes to it are dropped

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- wr_en  input  1  write request this cycle
- wr_addr  input  ADDR_W  destination register
- wr_data  input  WIDTH  write value
- rd_addr_a  input  ADDR_W  read port A address (for forward compare)
- rd_addr_b  input  ADDR_W  read port B address (for forward compare)
- reg_en  output  NREGS  one-hot register load enables; all zero when idle
- reg_data  output  WIDTH  data presented to all register D inputs
- pend_valid  output  1  pending stage holds a committable write
- pend_addr  output  ADDR_W  address held in pending stage
- fwd_a  output  1  rd_addr_a matches pending write
- fwd_b  output  1  rd_addr_b matches pending write

## Operation

- Pending stage: registers pend_valid, pend_addr, pend_data.
- Rising edge, reset low:
  - pend_valid <= wr_en & (wr_addr != ZERO_REG).
  - pend_addr <= wr_addr and pend_data <= wr_data when wr_en = 1; both hold when wr_en = 0.
- reg_en[i] = pend_valid & (pend_addr == i), for i in 0..NREGS-1. Built as an ADDR_W-to-NREGS decoder gated by pend_valid.
  - At most one bit is high.
  - reg_en[ZERO_REG] is always 0.
- reg_data = pend_data, driven continuously, whether or not a write is pending.
- fwd_a = pend_valid & (rd_addr_a == pend_addr); fwd_b is the same for rd_addr_b.
  - fwd_x is never 1 for ZERO_REG, because pend_valid is 0 for ZERO_REG. Reads of X31 therefore always return zero from the file side.
- No stall or backpressure: a new request every cycle overwrites the pending stage. Each write occupies the stage for exactly one cycle.
- Consecutive writes to the same address: each is committed in order. The second overwrites the first one cycle later.
- wr_en = 1 with wr_addr = ZERO_REG: the request is consumed and dropped. pend_valid = 0 the next cycle; pend_addr/pend_data still load. No reg_en bit is asserted.

## Timing

- Reset values (asynchronous, effective while reset = 1):
  - pend_valid = 0, pend_addr = 0, pend_data = 0.
  - Hence reg_en = 0, reg_data = 0, fwd_a = fwd_b = 0.
- Latency: a request sampled at edge N is visible on reg_en/reg_data/fwd_x during cycle N to N+1. It is loaded into the target register at edge N+1.
- fwd_a/fwd_b are combinational from the pending state and the rd_addr inputs. They are valid within the same cycle that rd_addr changes.
- Reset asserted mid-operation discards the pending write. The target register does not load, even if reset deasserts before the next edge.
- First edge after reset deasserts: normal sampling, with no extra idle cycle.
- Every output is a function of registered state plus rd_addr_a/b only. wr_* inputs have no combinational path to any output.

## Test plan

- Reset with garbage on the inputs: assert reset asynchronously between edges -> all outputs 0 immediately; reg_en = 32'h0 throughout.
- Single write: wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF_0000_0005 at edge N -> in cycle N+1, reg_en = 32'h0000_0020, reg_data = that value, pend_valid = 1. With wr_en=0 at edge N+1 -> reg_en = 0 in cycle N+2.
- Back-to-back: writes addr 3, addr 3, addr 7 on three consecutive edges -> reg_en sequence 0x8, 0x8, 0x80, then 0, each cycle carrying its own data in order.
- Zero register: wr_en=1, wr_addr=31, wr_data=64'h1 -> pend_valid=0 and reg_en=0 next cycle. rd_addr_a=31 -> fwd_a=0.
- Forwarding: pending write to addr 12. rd_addr_a=12, rd_addr_b=13 -> fwd_a=1, fwd_b=0. Change rd_addr_b to 12 in the same cycle -> fwd_b=1 with no clock edge.
- Reset mid-operation: write to addr 9 sampled, then reset pulsed for half a cycle before the next edge -> reg_en[9] drops to 0 at reset assertion and the next edge produces no load. Full 32-address sweep -> each reg_en bit is exercised exactly once, except bit 31.
